// File: rtl/combine_user_scheduler.sv
// Combine-engine user scheduler: serves the users masked at slot start in ascending index order.
// Optional WAIT watchdog enabled by defining COMBINE_SCHED_TIMEOUT_EN.
module combine_user_scheduler #(
  parameter int USER_NUM       = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       i_core_clk,
  input  logic       i_rx_rstn,
  input  logic       i_rdm_slot_start,
  input  logic [7:0] i_user_mask,
  input  logic       i_current_cb_combine_comp,
  output logic       o_combine_process_request,
  output logic [3:0] o_combine_user_index,
  output logic [7:0] o_pingpong_indicator,
  output logic       o_busy,
  output logic       o_slot_done,
  output logic       o_slot_overrun,
  output logic [7:0] o_timeout_flags
);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_SCAN = 5'b00010,
    S_REQ  = 5'b00100,
    S_WAIT = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

  localparam logic [7:0] USER_MASK = 8'((9'd1 << USER_NUM) - 9'd1);

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [3:0] index_q, index_d;
  logic [7:0] pingpong_q, pingpong_d;
  logic       overrun_q, overrun_d;
  logic [3:0] lowest_idx;

`ifdef COMBINE_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]       flags_q, flags_d;
  logic             timeout_hit;

  // Counter reads zero on the first WAIT cycle, so it is cleared on every WAIT entry.
  always_comb begin
    wait_cnt_d  = (state_q == S_WAIT) ? wait_cnt_q + 1'b1 : '0;
    timeout_hit = (wait_cnt_q == WAIT_LIMIT);
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      wait_cnt_q <= '0;
      flags_q    <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      flags_q    <= flags_d;
    end
  end

  assign o_timeout_flags = flags_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign o_timeout_flags    = 8'h00;
`endif

  // Lowest set pending bit wins: scan from the top so the last hit is the lowest.
  always_comb begin
    lowest_idx = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending_q[i]) lowest_idx = 4'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    index_d    = index_q;
    pingpong_d = pingpong_q;
    overrun_d  = i_rdm_slot_start && (state_q != S_IDLE);
`ifdef COMBINE_SCHED_TIMEOUT_EN
    flags_d    = flags_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_rdm_slot_start) begin
          pending_d = i_user_mask & USER_MASK;
`ifdef COMBINE_SCHED_TIMEOUT_EN
          flags_d   = 8'h00;
`endif
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (pending_q == 8'h00) begin
          state_d = S_DONE;
        end else begin
          index_d = lowest_idx;
          state_d = S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (i_current_cb_combine_comp) begin
          pending_d[index_q[2:0]]  = 1'b0;
          pingpong_d[index_q[2:0]] = ~pingpong_q[index_q[2:0]];
          state_d                  = S_SCAN;
        end
`ifdef COMBINE_SCHED_TIMEOUT_EN
        else if (timeout_hit) begin
          // Abandon this user without flipping its buffer half.
          pending_d[index_q[2:0]] = 1'b0;
          flags_d[index_q[2:0]]   = 1'b1;
          state_d                 = S_SCAN;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q    <= S_IDLE;
      pending_q  <= 8'h00;
      index_q    <= 4'd0;
      pingpong_q <= 8'h00;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      index_q    <= index_d;
      pingpong_q <= pingpong_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_combine_process_request = (state_q == S_REQ);
  assign o_slot_done               = (state_q == S_DONE);
  assign o_busy                    = (state_q != S_IDLE);
  assign o_combine_user_index      = index_q;
  assign o_pingpong_indicator      = pingpong_q;
  assign o_slot_overrun            = overrun_q;

endmodule
